// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, pixel/colour types and
// the 3-bit palette used by both the draw logic and the output stage.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [2:0] rgb_t;
    typedef logic [9:0] coord_t;

    // Colour bits are ordered {red, green, blue}
    localparam rgb_t BLACK   = 3'b000;
    localparam rgb_t BLUE    = 3'b001;
    localparam rgb_t GREEN   = 3'b010;
    localparam rgb_t CYAN    = 3'b011;
    localparam rgb_t RED     = 3'b100;
    localparam rgb_t MAGENTA = 3'b101;
    localparam rgb_t YELLOW  = 3'b110;
    localparam rgb_t WHITE   = 3'b111;

    function automatic logic inWindow(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register that lines up sync/active flags with the
// draw logic's colour latency; depth 0 degenerates to a wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_output_stage.sv
// VGA timing generator and output register stage: produces pixel coordinates
// for the draw logic and emits blanked colour with latency-matched syncs.
module vga_output_stage
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIX_DIV  = 2,
    parameter int RGB_LAT  = 1
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  rgb_t   i_rgb_in,
    output logic   o_pix_tick,
    output coord_t o_pix_x,
    output coord_t o_pix_y,
    output logic   o_pix_valid,
    output logic   o_frame_start,
    output logic   o_hsync,
    output logic   o_vsync,
    output logic   o_blank_n,
    output rgb_t   o_rgb_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    coord_t r_hCnt, r_vCnt;
    logic   r_pixTick, r_frameStart, r_pixValid, r_hsync, r_vsync, r_blankN;
    coord_t r_pixX, r_pixY;
    rgb_t   r_rgbOut;

    logic   w_advance, w_hWrap, w_validNext, w_hsRaw, w_vsRaw;
    coord_t w_hNext, w_vNext;
    logic [2:0] w_dly;

    assign w_advance = (r_div == DIV_W'(PIX_DIV - 1));

    // Everything downstream is computed from the coordinate being entered on this advance
    always_comb begin
        w_hWrap = (r_hCnt == coord_t'(H_TOTAL - 1));
        w_hNext = w_hWrap ? '0 : r_hCnt + coord_t'(1);
        w_vNext = r_vCnt;
        if (w_hWrap) begin
            w_vNext = (r_vCnt == coord_t'(V_TOTAL - 1)) ? '0 : r_vCnt + coord_t'(1);
        end
        w_validNext = (w_hNext < coord_t'(H_ACTIVE)) && (w_vNext < coord_t'(V_ACTIVE));
        w_hsRaw = inWindow(w_hNext, coord_t'(H_ACTIVE + H_FP), coord_t'(H_ACTIVE + H_FP + H_SYNC));
        w_vsRaw = inWindow(w_vNext, coord_t'(V_ACTIVE + V_FP), coord_t'(V_ACTIVE + V_FP + V_SYNC));
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (RGB_LAT)
    ) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_advance),
        .i_d     ({w_hsRaw, w_vsRaw, w_validNext}),
        .o_q     (w_dly)
    );

    // Counters start at the last position so the first advance lands on (0,0)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div        <= '0;
            r_hCnt       <= coord_t'(H_TOTAL - 1);
            r_vCnt       <= coord_t'(V_TOTAL - 1);
            r_pixTick    <= 1'b0;
            r_frameStart <= 1'b0;
            r_pixValid   <= 1'b0;
            r_pixX       <= '0;
            r_pixY       <= '0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_blankN     <= 1'b0;
            r_rgbOut     <= BLACK;
        end else begin
            r_div        <= w_advance ? '0 : r_div + DIV_W'(1);
            r_pixTick    <= w_advance;
            r_frameStart <= w_advance && (w_hNext == '0) && (w_vNext == '0);
            if (w_advance) begin
                r_hCnt     <= w_hNext;
                r_vCnt     <= w_vNext;
                r_pixValid <= w_validNext;
                r_pixX     <= w_validNext ? w_hNext : '0;
                r_pixY     <= w_validNext ? w_vNext : '0;
                r_hsync    <= ~w_dly[2];
                r_vsync    <= ~w_dly[1];
                r_blankN   <= w_dly[0];
                r_rgbOut   <= w_dly[0] ? i_rgb_in : BLACK;
            end
        end
    end

    assign o_pix_tick    = r_pixTick;
    assign o_frame_start = r_frameStart;
    assign o_pix_valid   = r_pixValid;
    assign o_pix_x       = r_pixX;
    assign o_pix_y       = r_pixY;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_blank_n     = r_blankN;
    assign o_rgb_out     = r_rgbOut;

endmodule

// File: tb/tb_vga_output_stage.sv
// Scoreboard bench for vga_output_stage: full horizontal timing with a
// shortened 9-line frame so whole frames and a mid-frame reset fit the run.
module tb_vga_output_stage;

    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 9;
    localparam int LINE_CLK  = 1600;
    localparam int FRAME_CLK = V_TOTAL * LINE_CLK;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       blank;
        logic [2:0] rgb;
    } obs_t;

    logic       clock = 1'b0;
    logic       rstN;
    logic [2:0] rgbIn;
    logic       pixTick, pixValid, frameStart, hsync, vsync, blankN;
    logic [9:0] pixX, pixY;
    logic [2:0] rgbOut;

    obs_t expQ[$];
    obs_t lastExp;
    bit   monActive = 1'b0;
    int   testsRun  = 0;
    int   failCount = 0;
    int   cyc       = 0;
    int   relCyc    = 0;

    always #10 clock = ~clock;

    vga_output_stage #(
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .PIX_DIV  (2),
        .RGB_LAT  (1)
    ) dut (
        .i_clk         (clock),
        .i_rst_n       (rstN),
        .i_rgb_in      (rgbIn),
        .o_pix_tick    (pixTick),
        .o_pix_x       (pixX),
        .o_pix_y       (pixY),
        .o_pix_valid   (pixValid),
        .o_frame_start (frameStart),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_blank_n     (blankN),
        .o_rgb_out     (rgbOut)
    );

    function automatic obs_t resetObs();
        obs_t e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Expected outputs during pixel tick n counted from reset release; the
    // draw-logic model drives rgb_in = column mod 8 one tick late.
    function automatic obs_t expAt(int n);
        obs_t e;
        int h, v, hp, vp;
        logic prevAct;
        h = n % H_TOTAL;
        v = (n / H_TOTAL) % V_TOTAL;
        e.tick  = 1'b1;
        e.valid = (h < 640) && (v < 4);
        e.x     = e.valid ? 10'(h) : 10'd0;
        e.y     = e.valid ? 10'(v) : 10'd0;
        e.fs    = (h == 0) && (v == 0);
        if (n == 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.rgb = 3'd0;
        end else begin
            hp = (n - 1) % H_TOTAL;
            vp = ((n - 1) / H_TOTAL) % V_TOTAL;
            prevAct = (hp < 640) && (vp < 4);
            e.hs    = !((hp >= 656) && (hp < 752));
            e.vs    = !((vp >= 5) && (vp < 7));
            e.blank = prevAct;
            e.rgb   = prevAct ? 3'(hp % 8) : 3'd0;
        end
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.tick = pixTick; s.x = pixX; s.y = pixY; s.valid = pixValid; s.fs = frameStart;
        s.hs = hsync; s.vs = vsync; s.blank = blankN; s.rgb = rgbOut;
        return s;
    endfunction

    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s @%0t: got tick=%b x=%0d y=%0d v=%b fs=%b hs=%b vs=%b bl=%b rgb=%0d, expected tick=%b x=%0d y=%0d v=%b fs=%b hs=%b vs=%b bl=%b rgb=%0d",
                     name, $time, act.tick, act.x, act.y, act.valid, act.fs, act.hs, act.vs, act.blank, act.rgb,
                     exp.tick, exp.x, exp.y, exp.valid, exp.fs, exp.hs, exp.vs, exp.blank, exp.rgb);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Junk is driven right after each advance and the real colour just before
    // the next one, so any sampling between advances shows up.
    task automatic applyStimulus(input int nTicks);
        int hp;
        for (int n = 0; n < nTicks; n++) begin
            @(negedge clock); #1;
            hp = (n - 1) % H_TOTAL;
            rgbIn = (n == 0) ? 3'b111 : 3'(hp % 8);
            expQ.push_back(expAt(n));
            @(negedge clock); #1;
            rgbIn = ~3'((n % H_TOTAL) % 8);
        end
    endtask

    always @(negedge clock) begin
        obs_t act;
        if (monActive) begin
            act = sample();
            if (pixTick) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    failCount++;
                    $display("[TB] FAIL unexpected tick @%0t: got pix_tick=1, expected none pending", $time);
                end else begin
                    lastExp = expQ.pop_front();
                    checkOutput("tick", act, lastExp);
                end
                lastExp.tick = 1'b0;
                lastExp.fs   = 1'b0;
            end else begin
                checkOutput("hold", act, lastExp);
            end
        end
    end

    int hFall, vFall, fsTime;
    bit hFallOk, vFallOk, fsOk;
    logic prevH = 1'b1, prevV = 1'b1;

    always @(negedge clock) begin
        cyc++;
        if (!monActive) begin
            hFallOk = 1'b0; vFallOk = 1'b0; fsOk = 1'b0;
            prevH = 1'b1; prevV = 1'b1;
        end else begin
            if (prevH && !hsync) begin
                if (hFallOk) checkCount("hsync period", cyc - hFall, LINE_CLK);
                hFall = cyc; hFallOk = 1'b1;
            end
            if (!prevH && hsync && hFallOk) checkCount("hsync low width", cyc - hFall, 192);
            if (prevV && !vsync) begin
                if (vFallOk) checkCount("vsync period", cyc - vFall, FRAME_CLK);
                vFall = cyc; vFallOk = 1'b1;
            end
            if (!prevV && vsync && vFallOk) checkCount("vsync low width", cyc - vFall, 2 * LINE_CLK);
            if (frameStart) begin
                if (fsOk) checkCount("frame period", cyc - fsTime, FRAME_CLK);
                else      checkCount("release to frame_start", cyc - relCyc, 2);
                fsTime = cyc; fsOk = 1'b1;
            end
            prevH = hsync;
            prevV = vsync;
        end
    end

    initial begin
        rstN  = 1'b0;
        rgbIn = 3'b111;
        repeat (5) begin
            @(negedge clock);
            checkOutput("reset hold", sample(), resetObs());
        end

        #1;
        relCyc    = cyc;
        lastExp   = resetObs();
        rstN      = 1'b1;
        monActive = 1'b1;
        // One full frame, then up to pixel (300,2) of the next
        applyStimulus(V_TOTAL * H_TOTAL + 2 * H_TOTAL + 301);

        rstN      = 1'b0;
        monActive = 1'b0;
        @(negedge clock);
        checkOutput("mid-frame reset", sample(), resetObs());
        checkCount("queue drained at reset", expQ.size(), 0);
        #1;
        relCyc    = cyc;
        lastExp   = resetObs();
        rstN      = 1'b1;
        monActive = 1'b1;
        applyStimulus(V_TOTAL * H_TOTAL + H_TOTAL + 1);

        @(negedge clock); #1;
        monActive = 1'b0;
        checkCount("queue empty at end", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
